mips_fetch: RTL
===============

MIPS_FETCH -- requirements
Module: mips_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the instruction buffer entry count.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-006 SHALL have port imem_addr, output, 32, read address; bits [1:0] always 0.
REQ-007 SHALL have port imem_ack, input, 1, memory returns imem_rdata this cycle.
REQ-008 SHALL have port imem_rdata, input, 32, instruction word.
REQ-009 SHALL have port redirect, input, 1, taken beq/jump; fetch restarts at redirect_pc.
REQ-010 SHALL have port redirect_pc, input, 32, new fetch address; bits [1:0] ignored.
REQ-011 SHALL have port instr_valid, output, 1, buffer head holds an instruction.
REQ-012 SHALL have port instr_ready, input, 1, decode stage accepts the head.
REQ-013 SHALL have port instr, output, 32, head instruction word.
REQ-014 SHALL have port instr_pc, output, 32, address of head instruction.
REQ-015 SHALL have ports opcode (instr[31:26]) and funct (instr[5:0]), output, 6 each, fed to the control decoder.

Function
REQ-016 SHALL keep at most one memory request outstanding.
REQ-017 SHALL hold imem_req high and imem_addr stable from assertion until the cycle imem_ack is sampled high.
REQ-018 SHALL assert imem_req only when buffer occupancy after pending pops leaves a free slot for the response.
REQ-019 SHALL, on an accepted response, push {imem_rdata, fetch_pc} into the buffer and advance fetch_pc by 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 SHALL pop the head when instr_valid && instr_ready; push and pop in the same cycle SHALL both occur, including when full.
REQ-021 SHALL implement FSM states IDLE (no request), WAIT (request outstanding), DROP (outstanding response to discard).
REQ-022 SHALL transition IDLE->WAIT when a slot is free; WAIT->IDLE on ack; WAIT->DROP on redirect without ack; DROP->IDLE on ack, discarding rdata.
REQ-023 SHALL, on redirect, flush all buffer entries and load fetch_pc with {redirect_pc[31:2],2'b00} in the same cycle.
REQ-024 SHALL, when redirect and imem_ack coincide, discard rdata, not advance from the old PC, and enter IDLE.
REQ-025 SHALL deassert instr_valid in the cycle after redirect until a post-redirect response is buffered.
REQ-026 SHALL hold instr and instr_pc stable while instr_valid is high and instr_ready is low.
REQ-027 SHALL give a minimum latency of 1 cycle from imem_ack to instr_valid.

Reset
REQ-028 SHALL, while rst_n is low, force imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, state=IDLE, buffer empty, fetch_pc=RESET_PC.
REQ-029 SHALL, when reset asserts mid-request, abandon the request; a late imem_ack after release SHALL be ignored unless in WAIT.
REQ-030 SHALL issue the first request, at RESET_PC, in the first cycle after rst_n deasserts.

Structure
REQ-031 SHALL take the FSM state typedef, RESET_PC default and opcode field positions from shared package mips_pkg.
REQ-032 SHALL place the buffer in sub-module fetch_fifo (parameter DEPTH, push/pop/flush, full/empty).

Verification
REQ-033 SHALL cover reset release with 0-wait ack memory -> requests at 0x0, 0x4, 0x8; instr_pc sequence 0x0, 0x4, 0x8.
REQ-034 SHALL cover instr_ready held low for 10 cycles -> exactly 2 entries buffered, imem_req stays low, no entry lost or duplicated.
REQ-035 SHALL cover redirect to 0x100 while a 3-cycle ack to 0x8 is pending -> 0x8 word dropped, next instr_pc 0x100.
REQ-036 SHALL cover redirect to 0x203 in the same cycle as imem_ack -> rdata discarded, next imem_addr 0x200.
REQ-037 SHALL cover RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0.
REQ-038 SHALL cover rst_n pulsed low mid-WAIT -> outputs at reset values immediately, refetch from RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared fetch-stage types and constants for the MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] c_RESET_PC   = 32'h0000_0000;
    localparam int          c_OPCODE_MSB = 31;
    localparam int          c_OPCODE_LSB = 26;
    localparam int          c_FUNCT_MSB  = 5;
    localparam int          c_FUNCT_LSB  = 0;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Small circular instruction buffer with push, pop and flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W    = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign full      = (r_count == c_FULL_CNT);
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop && !empty;
    // A push into a full buffer is legal only when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);
    assign head_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/mips_fetch.sv
`default_nettype none
// ============================================================================
// Module   : mips_fetch
// Brief    : Instruction fetch stage: one-outstanding memory requester + buffer.
// Revision : 1.0 - initial release
// ============================================================================
module mips_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
);

    localparam logic [31:0] c_START_PC = {RESET_PC[31:2], 2'b00};

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  w_fetch_pc_next;
    logic [31:0]  r_req_addr;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic         w_slot_free;
    logic [63:0]  w_head;

    assign w_pop       = !w_empty && instr_ready;
    assign w_slot_free = !w_full || w_pop;

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_push          = 1'b0;
        if (redirect) w_fetch_pc_next = {redirect_pc[31:2], 2'b00};
        case (r_state)
            // A redirect flushes the buffer, so a slot is always free afterwards.
            ST_IDLE: if (redirect || w_slot_free) w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (imem_ack) begin
                    w_state_next = ST_IDLE;
                    if (!redirect) begin
                        w_push          = 1'b1;
                        w_fetch_pc_next = r_fetch_pc + 32'd4;
                    end
                end else if (redirect) begin
                    w_state_next = ST_DROP;
                end
            end
            ST_DROP: if (imem_ack) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= c_START_PC;
            r_req_addr <= c_START_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            // Frozen once a request is out so DROP keeps presenting the old address.
            if (r_state == ST_IDLE) r_req_addr <= w_fetch_pc_next;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data ({imem_rdata, r_fetch_pc}),
        .pop       (w_pop),
        .flush     (redirect),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign imem_req    = (r_state != ST_IDLE);
    assign imem_addr   = (r_state == ST_IDLE) ? r_fetch_pc : r_req_addr;
    assign instr_valid = !w_empty;
    assign instr       = instr_valid ? w_head[63:32] : 32'h0;
    assign instr_pc    = instr_valid ? w_head[31:0]  : 32'h0;
    assign opcode      = instr[c_OPCODE_MSB:c_OPCODE_LSB];
    assign funct       = instr[c_FUNCT_MSB:c_FUNCT_LSB];

endmodule
`default_nettype wire
